// File: rtl/controle_passo.sv
// Step controller for the MIPS board build: debounced manual stepping or
// prescaled automatic stepping, a one-cycle processor advance pulse, a 0-99 step
// counter and a saturating 0-9999 capture of the processor result.
module controle_passo #(
    parameter int unsigned DEBOUNCE_CICLOS = 50000,
    parameter int unsigned AUTO_DIV        = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        botao,
    input  logic        modo_auto,
    input  logic [31:0] valor_cpu,
    output logic        pulso_cpu,
    output logic [9:0]  clock_atual,
    output logic [31:0] entrada,
    output logic        saturado
);

    localparam int unsigned DebW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam int unsigned DivW = $clog2(AUTO_DIV);
    localparam logic [DebW-1:0] DebLast  = DebW'(DEBOUNCE_CICLOS - 1);
    localparam logic [DivW-1:0] DivLast  = DivW'(AUTO_DIV - 1);
    localparam logic [31:0]     ValorMax = 32'd9999;
    localparam logic [9:0]      ContaMax = 10'd99;

    typedef enum logic [1:0] {
        StOcioso,
        StPulso,
        StCaptura
    } estado_e;

    // Synchronizers
    logic botao_s1_q, botao_s2_q;
    logic modo_s1_q, modo_s2_q;

    // Debounce
    logic            aceito_q, aceito_d;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic            evento_press;

    // Prescaler
    logic [DivW-1:0] div_q, div_d;
    logic            tick_auto;

    // Step FSM and outputs
    estado_e     estado_q, estado_d;
    logic        pedido;
    logic        pulso_q, pulso_d;
    logic        captura_en;
    logic [9:0]  conta_q, conta_d;
    logic [31:0] entrada_q, entrada_d;
    logic        saturado_q, saturado_d;

    // Two-flop synchronizers for the asynchronous button and mode inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            botao_s1_q <= 1'b1;
            botao_s2_q <= 1'b1;
            modo_s1_q  <= 1'b0;
            modo_s2_q  <= 1'b0;
        end else begin
            botao_s1_q <= botao;
            botao_s2_q <= botao_s1_q;
            modo_s1_q  <= modo_auto;
            modo_s2_q  <= modo_s1_q;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CICLOS consecutive differing samples.
    always_comb begin
        aceito_d     = aceito_q;
        deb_cnt_d    = '0;
        evento_press = 1'b0;
        if (botao_s2_q != aceito_q) begin
            if (deb_cnt_q == DebLast) begin
                aceito_d     = botao_s2_q;
                // Only the released-to-pressed transition is a press event.
                evento_press = aceito_q & ~botao_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DebW'(1);
            end
        end
    end

    // Prescaler: free-runs while in auto mode, parked at zero otherwise.
    always_comb begin
        div_d     = '0;
        tick_auto = 1'b0;
        if (modo_s2_q) begin
            if (div_q == DivLast) begin
                tick_auto = 1'b1;
            end else begin
                div_d = div_q + DivW'(1);
            end
        end
    end

    // Press events are discarded in auto mode and ticks cannot occur in manual mode.
    assign pedido = modo_s2_q ? tick_auto : evento_press;

    // State register for debounce, prescaler and FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            aceito_q  <= 1'b1;
            deb_cnt_q <= '0;
            div_q     <= '0;
            estado_q  <= StOcioso;
        end else begin
            aceito_q  <= aceito_d;
            deb_cnt_q <= deb_cnt_d;
            div_q     <= div_d;
            estado_q  <= estado_d;
        end
    end

    // Next-state logic; requests outside StOcioso are dropped.
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            StOcioso:  if (pedido) estado_d = StPulso;
            StPulso:   estado_d = StCaptura;
            StCaptura: estado_d = StOcioso;
            default:   estado_d = StOcioso;
        endcase
    end

    // Output decode: registered pulse and capture values for the PULSO->CAPTURA edge.
    always_comb begin
        pulso_d    = (estado_d == StPulso);
        captura_en = (estado_q == StPulso);
        conta_d    = conta_q;
        entrada_d  = entrada_q;
        saturado_d = saturado_q;
        if (captura_en) begin
            conta_d = (conta_q == ContaMax) ? 10'd0 : conta_q + 10'd1;
            if (valor_cpu > ValorMax) begin
                entrada_d  = ValorMax;
                saturado_d = 1'b1;
            end else begin
                entrada_d  = valor_cpu;
                saturado_d = 1'b0;
            end
        end
    end

    // Output registers; reset aborts a pulse in progress and its pending capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            pulso_q    <= 1'b0;
            conta_q    <= '0;
            entrada_q  <= '0;
            saturado_q <= 1'b0;
        end else begin
            pulso_q    <= pulso_d;
            conta_q    <= conta_d;
            entrada_q  <= entrada_d;
            saturado_q <= saturado_d;
        end
    end

    assign pulso_cpu   = pulso_q;
    assign clock_atual = conta_q;
    assign entrada     = entrada_q;
    assign saturado    = saturado_q;

endmodule

// File: tb/tb_controle_passo.sv
// Self-checking bench for controle_passo with DEBOUNCE_CICLOS=4, AUTO_DIV=10.
module tb_controle_passo;

    localparam int unsigned D    = 4;
    localparam int unsigned ADIV = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        botao = 1'b1;
    logic        modo_auto = 1'b0;
    logic [31:0] valor_cpu = '0;
    logic        pulso_cpu;
    logic [9:0]  clock_atual;
    logic [31:0] entrada;
    logic        saturado;

    int n_checks = 0;
    int n_pass   = 0;

    controle_passo #(
        .DEBOUNCE_CICLOS(D),
        .AUTO_DIV       (ADIV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .botao      (botao),
        .modo_auto  (modo_auto),
        .valor_cpu  (valor_cpu),
        .pulso_cpu  (pulso_cpu),
        .clock_atual(clock_atual),
        .entrada    (entrada),
        .saturado   (saturado)
    );

    always #5 clock = ~clock;

    // Reference model: inputs are seen two edges late; a level is accepted after a run
    // of D differing samples; auto ticks fall on every multiple of ADIV within a run of
    // auto-mode samples; a step starting at edge s pulses after s, captures at s+1 and
    // can only be followed by another step at s+3 or later.
    int          m_cyc, m_last, m_run_b, m_run_m, m_cnt;
    logic [1:0]  m_bq, m_mq;
    logic        m_acc, m_pulse, m_sat, m_sb, m_sm, m_press, m_tick, m_req;
    logic [31:0] m_ent;

    always @(posedge clock) begin
        if (reset) begin
            m_bq = 2'b11; m_mq = 2'b00; m_acc = 1'b1;
            m_run_b = 0; m_run_m = 0; m_cyc = 0; m_last = -100;
            m_pulse = 1'b0; m_cnt = 0; m_ent = '0; m_sat = 1'b0;
        end else begin
            m_cyc = m_cyc + 1;
            m_sb = m_bq[1];
            m_sm = m_mq[1];
            if (m_last == m_cyc - 1) begin
                m_ent = (valor_cpu > 32'd9999) ? 32'd9999 : valor_cpu;
                m_sat = (valor_cpu > 32'd9999);
                m_cnt = (m_cnt + 1) % 100;
            end
            m_press = 1'b0;
            if (m_sb != m_acc) begin
                m_run_b = m_run_b + 1;
                if (m_run_b == D) begin
                    m_acc = m_sb; m_run_b = 0; m_press = !m_sb;
                end
            end else begin
                m_run_b = 0;
            end
            m_run_m = m_sm ? m_run_m + 1 : 0;
            m_tick  = (m_run_m > 0) && (m_run_m % ADIV == 0);
            m_req   = m_sm ? m_tick : m_press;
            m_pulse = 1'b0;
            if (m_req && (m_cyc - m_last >= 3)) begin
                m_last = m_cyc; m_pulse = 1'b1;
            end
            m_bq = {m_bq[0], botao};
            m_mq = {m_mq[0], modo_auto};
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; botao = 1'b1; modo_auto = 1'b0;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; botao = 1'b1; modo_auto = 1'b0; valor_cpu = 32'd555;
        repeat (2) step();
        n_checks++;
        if ({pulso_cpu, clock_atual, entrada, saturado} !== '0)
            $display("FAIL reset_state: got p=%b c=%0d e=%0d s=%b required all 0",
                     pulso_cpu, clock_atual, entrada, saturado);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            n_checks++;
            if (pulso_cpu !== 1'b0) $display("FAIL idle_pulse: cycle %0d got %b required 0", i, pulso_cpu);
            else n_pass++;
        end
        n_checks++;
        if (clock_atual !== 10'd0) $display("FAIL idle_count: got %0d required 0", clock_atual);
        else n_pass++;
        n_checks++;
        if (entrada !== 32'd0 || saturado !== 1'b0)
            $display("FAIL idle_entrada: got %0d/%b required 0/0", entrada, saturado);
        else n_pass++;
    endtask

    task automatic test_manual();
        logic        exp_p;
        logic [31:0] exp_e;
        logic [9:0]  exp_c;
        do_reset();
        valor_cpu = 32'd1234;
        botao = 1'b0;
        // k-th sample is taken after edge t0+k.
        for (int k = 0; k < 12; k++) begin
            step();
            exp_p = (k == 5);
            exp_e = (k >= 6) ? 32'd1234 : 32'd0;
            exp_c = (k >= 6) ? 10'd1 : 10'd0;
            n_checks++;
            if (pulso_cpu !== exp_p) $display("FAIL manual_pulse: k=%0d got %b required %b", k, pulso_cpu, exp_p);
            else n_pass++;
            n_checks++;
            if (entrada !== exp_e || clock_atual !== exp_c)
                $display("FAIL manual_capture: k=%0d got %0d/%0d required %0d/%0d",
                         k, entrada, clock_atual, exp_e, exp_c);
            else n_pass++;
        end
        valor_cpu = 32'd555;
        for (int i = 0; i < 30; i++) begin
            step();
            n_checks++;
            if (pulso_cpu !== 1'b0 || entrada !== 32'd1234)
                $display("FAIL manual_held: cycle %0d got p=%b e=%0d required 0/1234", i, pulso_cpu, entrada);
            else n_pass++;
        end
        botao = 1'b1;
        repeat (D + 6) step();
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        pat = 6'b000100;  // index 0 first: low 2, high 1, low 3
        do_reset();
        for (int i = 0; i < 26; i++) begin
            botao = (i < 6) ? pat[i] : 1'b1;
            step();
            n_checks++;
            if (pulso_cpu !== 1'b0) $display("FAIL bounce_pulse: cycle %0d got %b required 0", i, pulso_cpu);
            else n_pass++;
        end
        n_checks++;
        if (clock_atual !== 10'd0) $display("FAIL bounce_count: got %0d required 0", clock_atual);
        else n_pass++;
    endtask

    task automatic test_saturate();
        logic [31:0] v;
        logic [31:0] exp_e;
        logic        exp_s;
        logic        got;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      v = 32'hFFFF_FFFF;
            else if (i == 1) v = 32'd42;
            else if (i == 2) v = 32'd10000;
            else if (i == 3) v = 32'd9999;
            else v = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 9999)) : $urandom;
            exp_e = (v > 32'd9999) ? 32'd9999 : v;
            exp_s = (v > 32'd9999);
            valor_cpu = v;
            botao = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                step();
                if (pulso_cpu === 1'b1) got = 1'b1;
            end
            n_checks++;
            if (got !== 1'b1) $display("FAIL sat_press_pulse: press %0d got %b required 1", i, got);
            else n_pass++;
            step();
            n_checks++;
            if (entrada !== exp_e || saturado !== exp_s)
                $display("FAIL sat_capture: v=%0h got %0d/%b required %0d/%b", v, entrada, saturado, exp_e, exp_s);
            else n_pass++;
            n_checks++;
            if (clock_atual !== 10'(i + 1)) $display("FAIL sat_count: got %0d required %0d", clock_atual, i + 1);
            else n_pass++;
            botao = 1'b1;
            repeat (D + 6) step();
        end
    endtask

    task automatic test_auto();
        int npulse;
        int last;
        npulse = 0;
        last = -1;
        do_reset();
        modo_auto = 1'b1;
        valor_cpu = 32'd77;
        for (int i = 0; i < 1005; i++) begin
            botao = (((i / 8) % 2) == 0) ? 1'b0 : 1'b1;
            step();
            n_checks++;
            if (pulso_cpu !== m_pulse) $display("FAIL auto_pulse: cycle %0d got %b required %b", i, pulso_cpu, m_pulse);
            else n_pass++;
            n_checks++;
            if (clock_atual !== 10'(m_cnt)) $display("FAIL auto_count: cycle %0d got %0d required %0d", i, clock_atual, m_cnt);
            else n_pass++;
            if (pulso_cpu === 1'b1) begin
                npulse++;
                if (last >= 0) begin
                    n_checks++;
                    if (i - last !== ADIV) $display("FAIL auto_spacing: got %0d required %0d", i - last, ADIV);
                    else n_pass++;
                end
                last = i;
            end
        end
        n_checks++;
        if (npulse !== 100) $display("FAIL auto_steps: got %0d required 100", npulse);
        else n_pass++;
        n_checks++;
        if (clock_atual !== 10'd0) $display("FAIL auto_wrap: got %0d required 0", clock_atual);
        else n_pass++;
        modo_auto = 1'b0;
        botao = 1'b1;
        repeat (D + 6) step();
    endtask

    task automatic test_reset_in_pulse();
        logic got;
        do_reset();
        valor_cpu = 32'd7;
        botao = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            if (pulso_cpu === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (got !== 1'b1) $display("FAIL rip_first_pulse: got %b required 1", got);
        else n_pass++;
        reset = 1'b1;
        step();
        n_checks++;
        if ({pulso_cpu, clock_atual, entrada, saturado} !== '0)
            $display("FAIL rip_abort: got p=%b c=%0d e=%0d s=%b required all 0",
                     pulso_cpu, clock_atual, entrada, saturado);
        else n_pass++;
        reset = 1'b0;
        // Button still held through reset release: exactly one more press event.
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            if (pulso_cpu === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (got !== 1'b1) $display("FAIL rip_held_pulse: got %b required 1", got);
        else n_pass++;
        step();
        n_checks++;
        if (entrada !== 32'd7 || clock_atual !== 10'd1)
            $display("FAIL rip_capture: got %0d/%0d required 7/1", entrada, clock_atual);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (pulso_cpu !== 1'b0) $display("FAIL rip_single: cycle %0d got %b required 0", i, pulso_cpu);
            else n_pass++;
        end
        botao = 1'b1;
        repeat (D + 6) step();
    endtask

    task automatic test_random();
        int hold_b;
        int hold_m;
        hold_b = 1;
        hold_m = 100;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            hold_b--;
            if (hold_b == 0) begin
                botao = ~botao;
                hold_b = $urandom_range(1, 9);
            end
            hold_m--;
            if (hold_m == 0) begin
                modo_auto = ~modo_auto;
                hold_m = $urandom_range(40, 200);
            end
            valor_cpu = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20000)) : $urandom;
            step();
            n_checks++;
            if (pulso_cpu !== m_pulse) $display("FAIL rand_pulse: cycle %0d got %b required %b", i, pulso_cpu, m_pulse);
            else n_pass++;
            n_checks++;
            if (entrada !== m_ent || saturado !== m_sat || clock_atual !== 10'(m_cnt))
                $display("FAIL rand_outputs: cycle %0d got %0d/%b/%0d required %0d/%b/%0d",
                         i, entrada, saturado, clock_atual, m_ent, m_sat, m_cnt);
            else n_pass++;
        end
        modo_auto = 1'b0;
        botao = 1'b1;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_bounce();
        test_saturate();
        test_auto();
        test_reset_in_pulse();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
